conv2d_window_driver: RTL and testbench

//   Initiator for the 3x3 conv core (start/9-pixel/9-weight/out/done interface).

---
 rtl/conv2d_window_driver.sv | 186 ++++++++++++++++++
 tb/tb_conv2d_window_driver.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_window_driver.sv
// Purpose : forms 3x3 windows from a raster pixel stream and drives one 3x3 conv core transaction per window.
// Latency : window issued the cycle after its last pixel is accepted; result valid the cycle after conv_done.
// Backpr. : pix_ready low from window issue until the result is taken (or the window times out).
module conv2d_window_driver #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        k_wr_en,
    input  logic [3:0]  k_wr_addr,
    input  logic [7:0]  k_wr_data,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        conv_start,
    output logic [71:0] conv_win,
    output logic [71:0] conv_k,
    input  logic [15:0] conv_out,
    input  logic        conv_done,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_last,
    input  logic        res_ready,
    output logic        busy,
    output logic        err_timeout
);

    localparam int CW = (IMG_W   > 2) ? $clog2(IMG_W)   : 1;
    localparam int RW = (IMG_H   > 2) ? $clog2(IMG_H)   : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_k [9];

    // Line buffers indexed by column: r_lb1 holds row r-1, r_lb2 holds row r-2.
    logic [7:0]    r_lb1 [IMG_W];
    logic [7:0]    r_lb2 [IMG_W];

    // Per-row shift pairs: *0 = column c-2, *1 = column c-1 of the current row.
    logic [7:0]    r_t0, r_t1, r_m0, r_m1, r_b0, r_b1;

    logic [71:0]   r_win;
    logic          r_last_pend;
    logic          r_start;
    logic          r_res_valid;
    logic [15:0]   r_res_data;
    logic          r_res_last;
    logic          r_err;

    logic          w_fill;
    logic          w_accept;
    logic [7:0]    w_top;
    logic [7:0]    w_mid;
    logic          w_col_end;
    logic          w_row_end;
    logic          w_win_pos;
    logic          w_k_wr;

    assign w_fill    = (r_state == S_FILL);
    assign w_accept  = pix_valid & w_fill;
    assign w_top     = r_lb2[r_col];
    assign w_mid     = r_lb1[r_col];
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));
    assign w_win_pos = (r_row >= RW'(2)) && (r_col >= CW'(2));
    // Weights only change between windows so the core always sees a frozen kernel.
    assign w_k_wr    = k_wr_en & w_fill & (k_wr_addr < 4'd9);

    // Line buffers and shift pairs advance on every accepted pixel; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= w_mid;
            r_lb1[r_col] <= pix_data;
            r_t0         <= r_t1;
            r_t1         <= w_top;
            r_m0         <= r_m1;
            r_m1         <= w_mid;
            r_b0         <= r_b1;
            r_b1         <= pix_data;
        end
    end

    // Kernel weight registers, writable only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                r_k[i] <= 8'd0;
            end
        end else if (w_k_wr) begin
            r_k[k_wr_addr] <= k_wr_data;
        end
    end

    // Control FSM: raster position, window capture, core handshake, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_col       <= '0;
            r_row       <= '0;
            r_timer     <= '0;
            r_win       <= '0;
            r_last_pend <= 1'b0;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (w_col_end) begin
                            r_col <= '0;
                            r_row <= w_row_end ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        // Window spans rows r-2..r, columns c-2..c; in0 is top-left.
                        if (w_win_pos) begin
                            r_win       <= {pix_data, r_b1, r_b0,
                                            w_mid,    r_m1, r_m0,
                                            w_top,    r_t1, r_t0};
                            r_last_pend <= w_row_end & w_col_end;
                            r_start     <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // conv_done during the start cycle is deliberately not looked at.
                    r_start <= 1'b0;
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done on the last allowed cycle still wins over the timeout.
                    if (conv_done) begin
                        r_res_data  <= conv_out;
                        r_res_last  <= r_last_pend;
                        r_res_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_FILL;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_last  <= 1'b0;
                        r_state     <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign pix_ready   = w_fill;
    assign busy        = ~w_fill;
    assign conv_start  = r_start;
    assign conv_win    = r_win;
    assign conv_k      = {r_k[8], r_k[7], r_k[6], r_k[5], r_k[4],
                          r_k[3], r_k[2], r_k[1], r_k[0]};
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_last    = r_res_last;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_conv2d_window_driver.sv
// Purpose : checks conv2d_window_driver against an event-level frame/window model plus literal scenarios.
// Latency : core stub answers 1..N cycles after start, or never, or with a spurious done on the start cycle.
// Backpr. : res_ready held low / randomized to exercise result hold and input stall.
module tb_conv2d_window_driver;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        k_wr_en = 1'b0;
    logic [3:0]  k_wr_addr = 4'd0;
    logic [7:0]  k_wr_data = 8'd0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        pix_ready;
    logic        conv_start;
    logic [71:0] conv_win;
    logic [71:0] conv_k;
    logic [15:0] conv_out = 16'd0;
    logic        conv_done = 1'b0;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_last;
    logic        res_ready = 1'b1;
    logic        busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    conv2d_window_driver #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .conv_start(conv_start), .conv_win(conv_win), .conv_k(conv_k),
        .conv_out(conv_out), .conv_done(conv_done),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .res_ready(res_ready), .busy(busy), .err_timeout(err_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dot(input logic [71:0] w, input logic [71:0] k);
        int unsigned s;
        s = 0;
        for (int i = 0; i < 9; i++) s += w[8*i +: 8] * k[8*i +: 8];
        return s[15:0];
    endfunction

    // ---------------- conv core stub ----------------
    int   core_lat_max    = 1;
    int   core_nodone_pct = 0;
    bit   core_garbage    = 1'b0;
    int   core_cnt        = 0;
    logic [15:0] core_val = 16'd0;
    logic core_rs;

    always begin
        @(posedge clk);
        core_rs = rst;
        #1;
        conv_done = 1'b0;
        conv_out  = 16'($urandom);
        if (core_rs) begin
            core_cnt = 0;
        end else if (conv_start) begin
            core_val = dot(conv_win, conv_k);
            core_cnt = ($urandom_range(99) < core_nodone_pct) ? 0 : int'($urandom_range(core_lat_max, 1));
            if (core_garbage && $urandom_range(3) == 0) conv_done = 1'b1;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                conv_done = 1'b1;
                conv_out  = core_val;
            end
        end
    end

    // ---------------- behavioural model + compare ----------------
    logic [7:0]  img [H][W];
    logic [7:0]  mk  [9];
    int          mr = 0, mc = 0;
    int          cyc = 0, ws = 0;
    bit          exp_busy = 0, exp_start = 0, exp_valid = 0, exp_err = 0, waiting = 0;
    logic [71:0] exp_win = '0;
    logic [15:0] exp_dot = '0, exp_data = '0;
    bit          exp_lastp = 0, exp_last = 0;
    logic [16:0] got_q [$];

    initial for (int i = 0; i < 9; i++) mk[i] = 8'd0;

    function automatic logic [71:0] kpack();
        logic [71:0] k;
        for (int i = 0; i < 9; i++) k[8*i +: 8] = mk[i];
        return k;
    endfunction

    always @(negedge clk) begin
        cyc++;
        chk("busy", busy, exp_busy);
        chk("pix_ready", pix_ready, !exp_busy);
        chk("conv_start", conv_start, exp_start);
        chk("res_valid", res_valid, exp_valid);
        chk("err_timeout", err_timeout, exp_err);
        chk("conv_k", conv_k, kpack());
        if (exp_busy) chk("conv_win", conv_win, exp_win);
        if (exp_valid) begin
            chk("res_data", res_data, exp_data);
            chk("res_last", res_last, exp_last);
        end
        if (rst) begin
            exp_busy = 0; exp_start = 0; exp_valid = 0; exp_err = 0; waiting = 0;
            mr = 0; mc = 0;
            for (int i = 0; i < 9; i++) mk[i] = 8'd0;
        end else if (exp_start) begin
            exp_start = 0; waiting = 1; ws = cyc;
        end else if (waiting) begin
            if (conv_done === 1'b1) begin
                waiting = 0; exp_valid = 1; exp_data = exp_dot; exp_last = exp_lastp;
            end else if (cyc - ws == TO) begin
                waiting = 0; exp_busy = 0; exp_err = 1;
            end
        end else if (exp_valid) begin
            if (res_ready) begin
                got_q.push_back({res_last, res_data});
                exp_valid = 0; exp_busy = 0;
            end
        end else begin
            if (k_wr_en && k_wr_addr < 4'd9) mk[k_wr_addr] = k_wr_data;
            if (pix_valid) begin
                img[mr][mc] = pix_data;
                if (mr >= 2 && mc >= 2) begin
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            exp_win[8*(3*rr+cc) +: 8] = img[mr-2+rr][mc-2+cc];
                    exp_dot   = dot(exp_win, kpack());
                    exp_lastp = (mr == H-1) && (mc == W-1);
                    exp_busy  = 1; exp_start = 1;
                end
                if (mc == W-1) begin
                    mc = 0; mr = (mr == H-1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_valid = 1'b0; k_wr_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_k(input int a, input int d);
        k_wr_en = 1'b1; k_wr_addr = 4'(a); k_wr_data = 8'(d);
        tick();
        k_wr_en = 1'b0;
    endtask

    task automatic set_k_all(input int d);
        for (int i = 0; i < 9; i++) wr_k(i, d);
    endtask

    task automatic send_pix(input int d);
        bit acc;
        int n;
        acc = 1'b0; n = 0;
        pix_valid = 1'b1; pix_data = 8'(d);
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = pix_ready;
            tick();
            n++;
        end
        pix_valid = 1'b0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_pix: pixel not accepted within 200 cycles");
        end
    endtask

    task automatic wait_results(input string nm, input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 300) begin tick(); k++; end
        chk(nm, got_q.size(), n);
    endtask

    task automatic wait_start(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (conv_start !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        chk(nm, conv_start, 1'b1);
    endtask

    task automatic check_ones_frame(input string nm);
        logic [16:0] g;
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 17'h1ffff;
            chk({nm, " data"}, g[15:0], 16'd9);
            chk({nm, " last"}, g[16], (i == 3));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [16:0] g;
        int ev [4];
        ev = '{5, 6, 9, 10};

        tick(); tick();
        chk("reset conv_win", conv_win, 72'd0);
        chk("reset res_data", res_data, 16'd0);
        rst = 1'b0;

        // 1: all-ones frame, all-ones kernel
        set_k_all(1);
        got_q.delete();
        for (int i = 0; i < 16; i++) send_pix(1);
        wait_results("s1 count", 4);
        check_ones_frame("s1");
        chk("s1 err", err_timeout, 1'b0);

        // 2: ramp 0..15, centre-tap kernel
        do_reset();
        wr_k(4, 1);
        got_q.delete();
        for (int i = 0; i < 16; i++) send_pix(i);
        wait_results("s2 count", 4);
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 17'h1ffff;
            chk("s2 data", g[15:0], 16'(ev[i]));
        end

        // 3: core never answers -> timeout, then next window normal
        do_reset();
        set_k_all(1);
        core_nodone_pct = 100;
        got_q.delete();
        for (int i = 0; i <= 10; i++) send_pix(i);
        wait_start("s3 start");
        repeat (TO) @(negedge clk);
        chk("s3 err before", err_timeout, 1'b0);
        @(negedge clk);
        chk("s3 err after", err_timeout, 1'b1);
        chk("s3 busy after", busy, 1'b0);
        tick();
        core_nodone_pct = 0;
        send_pix(11);
        wait_results("s3 count", 1);
        g = (got_q.size() > 0) ? got_q[0] : 17'h1ffff;
        chk("s3 data", g[15:0], 16'd54);

        // 4: result held 10 cycles with res_ready low
        do_reset();
        set_k_all(1);
        res_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i <= 10; i++) send_pix(1);
        pix_valid = 1'b1; pix_data = 8'd1;
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (res_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        end
        for (int i = 0; i < 10; i++) begin
            chk("s4 res_data hold", res_data, 16'd9);
            chk("s4 pix_ready low", pix_ready, 1'b0);
            chk("s4 no start", conv_start, 1'b0);
            @(negedge clk);
        end
        tick();
        pix_valid = 1'b0; res_ready = 1'b1;
        wait_results("s4 count", 1);

        // 5: kernel write ignored while busy, honoured while idle
        // frame position now at pixel 11 (row 2, col 3)
        res_ready = 1'b0;
        got_q.delete();
        send_pix(1);
        wr_k(0, 2);
        chk("s5 k0 busy", conv_k[7:0], 8'd1);
        res_ready = 1'b1;
        wait_results("s5 first", 1);
        chk("s5 first data", got_q[0][15:0], 16'd9);
        wr_k(0, 2);
        chk("s5 k0 idle", conv_k[7:0], 8'd2);
        got_q.delete();
        for (int i = 0; i < 3; i++) send_pix(1);
        wait_results("s5 count", 1);
        g = (got_q.size() > 0) ? got_q[0] : 17'h1ffff;
        chk("s5 data", g[15:0], 16'd10);

        // 6: reset while waiting on the core
        core_nodone_pct = 100;
        send_pix(1);
        wait_start("s6 start");
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6 busy", busy, 1'b0);
        chk("s6 pix_ready", pix_ready, 1'b1);
        chk("s6 conv_start", conv_start, 1'b0);
        chk("s6 conv_win", conv_win, 72'd0);
        chk("s6 conv_k", conv_k, 72'd0);
        chk("s6 res_valid", res_valid, 1'b0);
        chk("s6 res_data", res_data, 16'd0);
        chk("s6 res_last", res_last, 1'b0);
        chk("s6 err", err_timeout, 1'b0);
        core_nodone_pct = 0;
        set_k_all(1);
        got_q.delete();
        for (int i = 0; i < 16; i++) send_pix(1);
        wait_results("s6 count", 4);
        check_ones_frame("s6");

        // randomized traffic against the model
        core_lat_max = 4; core_nodone_pct = 8; core_garbage = 1'b1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            pix_valid = ($urandom_range(9) < 8);
            pix_data  = 8'($urandom);
            res_ready = ($urandom_range(9) < 7);
            k_wr_en   = ($urandom_range(9) == 0);
            k_wr_addr = 4'($urandom);
            k_wr_data = 8'($urandom);
            rst       = ($urandom_range(999) == 0);
            tick();
        end
        rst = 1'b0; pix_valid = 1'b0; k_wr_en = 1'b0; res_ready = 1'b1;
        core_nodone_pct = 0; core_garbage = 1'b0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
